// File: rtl/memory_wait_if.sv
// Bus bundle for memory_wait: legacy ce/r/w/oe strobes, address/data, and the
// busy/done/err completion handshake.
interface memory_wait_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              ce;
    logic              r;
    logic              w;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output ce, r, w, oe, addr, in_data,
        input  out_data, busy, done, err
    );

    modport slave (
        input  ce, r, w, oe, addr, in_data,
        output out_data, busy, done, err
    );
endinterface

// File: rtl/memory_wait.sv
// Single-port synchronous RAM with a programmable wait-state engine.
// Each access takes WAIT+1 cycles and is reported by a one-cycle done/err pulse.
module memory_wait #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    memory_wait_if.slave  bus
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              op_rd_q, op_rd_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;

    // Full-width compare: an address at or above DEPTH never aliases into the array.
    assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
    assign mem_idx  = addr_q[IDX_W-1:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        op_rd_d = op_rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ce && (bus.r || bus.w)) begin
                    state_d = ST_BUSY;
                    cnt_d   = WAIT_INIT;
                    op_rd_d = bus.r;
                    addr_d  = bus.addr;
                    wdata_d = bus.in_data;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = !in_range;
                    if (op_rd_q) begin
                        data_d = in_range ? mem[mem_idx] : '0;
                    end else begin
                        mem_we = in_range;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_rd_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_rd_q <= op_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset; an abandoned write is blocked because reset forces ST_IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign bus.busy     = (state_q == ST_BUSY);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.out_data = (bus.ce && bus.oe) ? data_q : 'z;

endmodule

// File: tb/tb_memory_wait.sv
// Four memory_wait instances (different WAIT/DEPTH) share one stimulus stream and are
// compared every cycle against a timestamp-based reference model.
module tb_memory_wait;

    localparam int NI     = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int MAXD   = 1024;
    localparam int WAITS  [NI] = '{0, 2, 3, 4};
    localparam int DEPTHS [NI] = '{1024, 1024, 1024, 1000};

    logic              clk = 1'b0;
    logic              rst;
    logic              ce, r, w, oe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in_data;

    logic [DATA_W-1:0] obs_data [NI];
    logic              obs_busy [NI];
    logic              obs_done [NI];
    logic              obs_err  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        memory_wait_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
        assign bus.ce      = ce;
        assign bus.r       = r;
        assign bus.w       = w;
        assign bus.oe      = oe;
        assign bus.addr    = addr;
        assign bus.in_data = in_data;
        assign obs_data[g] = bus.out_data;
        assign obs_busy[g] = bus.busy;
        assign obs_done[g] = bus.done;
        assign obs_err[g]  = bus.err;

        memory_wait #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .DEPTH (DEPTHS[g]),
            .WAIT  (WAITS[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    // Reference model: memory image plus one pending access with its completion edge number.
    logic [DATA_W-1:0] mm [NI][MAXD];
    bit                mk [NI][MAXD];
    logic [DATA_W-1:0] m_data   [NI];
    bit                m_dknown [NI];
    bit                m_busy   [NI];
    bit                m_done   [NI];
    bit                m_err    [NI];
    bit                p_rd     [NI];
    int                p_addr   [NI];
    logic [DATA_W-1:0] p_wd     [NI];
    longint            p_edge   [NI];
    longint            edge_n;

    int done_cnt [NI];
    int err_cnt  [NI];
    int busy_cnt [NI];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            m_data[g]   = '0;
            m_dknown[g] = 1'b1;
            m_busy[g]   = 1'b0;
            m_done[g]   = 1'b0;
            m_err[g]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        edge_n++;
        for (int g = 0; g < NI; g++) begin
            m_done[g] = 1'b0;
            m_err[g]  = 1'b0;
            if (m_busy[g]) begin
                if (p_edge[g] == edge_n) begin
                    m_busy[g] = 1'b0;
                    m_done[g] = 1'b1;
                    m_err[g]  = (p_addr[g] >= DEPTHS[g]);
                    if (p_rd[g]) begin
                        if (p_addr[g] < DEPTHS[g]) begin
                            m_data[g]   = mm[g][p_addr[g]];
                            m_dknown[g] = mk[g][p_addr[g]];
                        end else begin
                            m_data[g]   = '0;
                            m_dknown[g] = 1'b1;
                        end
                    end else if (p_addr[g] < DEPTHS[g]) begin
                        mm[g][p_addr[g]] = p_wd[g];
                        mk[g][p_addr[g]] = 1'b1;
                    end
                end
            end else if (ce && (r || w)) begin
                m_busy[g] = 1'b1;
                p_edge[g] = edge_n + 1 + WAITS[g];
                p_rd[g]   = r;
                p_addr[g] = int'(addr);
                p_wd[g]   = in_data;
            end
        end
    endtask

    task automatic check_outputs();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("busy[%0d]", g), 32'(obs_busy[g]), 32'(m_busy[g]));
            check($sformatf("done[%0d]", g), 32'(obs_done[g]), 32'(m_done[g]));
            check($sformatf("err[%0d]", g),  32'(obs_err[g]),  32'(m_err[g]));
            if (ce && oe && m_dknown[g])
                check($sformatf("out_data[%0d]", g), 32'(obs_data[g]), 32'(m_data[g]));
            if (obs_done[g] === 1'b1) done_cnt[g]++;
            if (obs_err[g] === 1'b1)  err_cnt[g]++;
            if (obs_busy[g] === 1'b1) busy_cnt[g]++;
        end
    endtask

    task automatic clear_counts();
        for (int g = 0; g < NI; g++) begin
            done_cnt[g] = 0;
            err_cnt[g]  = 0;
            busy_cnt[g] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // One request cycle followed by enough idle cycles for the slowest instance to finish.
    task automatic access(input bit rr, input bit ww, input int a, input int d);
        ce      = 1'b1;
        oe      = 1'b1;
        r       = rr;
        w       = ww;
        addr    = ADDR_W'(a);
        in_data = DATA_W'(d);
        step();
        r = 1'b0;
        w = 1'b0;
        repeat (6) step();
    endtask

    task automatic drop_reset();
        rst = 1'b0;
        #1;
        model_reset();
        for (int g = 0; g < NI; g++)
            check($sformatf("rst_busy[%0d]", g), 32'(obs_busy[g]), 32'd0);
    endtask

    initial begin
        edge_n = 0;
        for (int g = 0; g < NI; g++) p_edge[g] = 0;
        rst = 1'b1; ce = 1'b1; oe = 1'b1; r = 1'b0; w = 1'b0; addr = '0; in_data = '0;
        clear_counts();

        // Reset state
        #2;
        drop_reset();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_data[%0d]", g), 32'(obs_data[g]), 32'h00);
            check($sformatf("rst_done[%0d]", g), 32'(obs_done[g]), 32'd0);
            check($sformatf("rst_err[%0d]", g),  32'(obs_err[g]),  32'd0);
        end
        @(negedge clk);
        step();
        rst = 1'b1;

        // Write then read
        clear_counts();
        access(1'b0, 1'b1, 'h0010, 'hA5);
        for (int g = 0; g < NI; g++)
            check($sformatf("wr_busy_cycles[%0d]", g), 32'(busy_cnt[g]), 32'(WAITS[g] + 1));
        clear_counts();
        access(1'b1, 1'b0, 'h0010, 'h00);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rd_busy_cycles[%0d]", g), 32'(busy_cnt[g]), 32'(WAITS[g] + 1));
            check($sformatf("rd_done_cnt[%0d]", g),    32'(done_cnt[g]), 32'd1);
            check($sformatf("rd_a5[%0d]", g),          32'(obs_data[g]), 32'hA5);
        end

        // Simultaneous r and w: read wins
        access(1'b0, 1'b1, 5, 'h3C);
        access(1'b1, 1'b1, 5, 'hFF);
        for (int g = 0; g < NI; g++)
            check($sformatf("rw_read[%0d]", g), 32'(obs_data[g]), 32'h3C);
        access(1'b1, 1'b0, 5, 'h00);
        for (int g = 0; g < NI; g++)
            check($sformatf("rw_mem5[%0d]", g), 32'(obs_data[g]), 32'h3C);

        // Out of range
        access(1'b0, 1'b1, 'h0000, 'h5A);
        clear_counts();
        access(1'b0, 1'b1, 'h0400, 'h77);
        for (int g = 0; g < NI; g++)
            check($sformatf("oor_wr_err[%0d]", g), 32'(err_cnt[g]), 32'd1);
        clear_counts();
        access(1'b1, 1'b0, 'h0400, 'h00);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("oor_rd_err[%0d]", g),  32'(err_cnt[g]),  32'd1);
            check($sformatf("oor_rd_data[%0d]", g), 32'(obs_data[g]), 32'h00);
        end
        access(1'b1, 1'b0, 'h0000, 'h00);
        for (int g = 0; g < NI; g++)
            check($sformatf("oor_addr0[%0d]", g), 32'(obs_data[g]), 32'h5A);

        // Reset one cycle after a write is accepted
        access(1'b0, 1'b1, 7, 'h11);
        clear_counts();
        ce = 1'b1; w = 1'b1; r = 1'b0; addr = 7; in_data = 'h99;
        step();
        w = 1'b0;
        step();
        drop_reset();
        repeat (2) step();
        rst = 1'b1;
        repeat (6) step();
        for (int g = 1; g < NI; g++)
            check($sformatf("rstmid_no_done[%0d]", g), 32'(done_cnt[g]), 32'd0);
        access(1'b1, 1'b0, 7, 'h00);
        for (int g = 0; g < NI; g++)
            check($sformatf("rstmid_mem7[%0d]", g), 32'(obs_data[g]),
                  (WAITS[g] == 0) ? 32'h99 : 32'h11);

        // Back-to-back reads with the request held high
        access(1'b0, 1'b1, 1, 'h21);
        access(1'b0, 1'b1, 2, 'h22);
        access(1'b0, 1'b1, 3, 'h23);
        clear_counts();
        ce = 1'b1; r = 1'b1;
        for (int i = 0; i < 6; i++) begin
            addr = ADDR_W'(1 + i / 2);
            step();
        end
        r = 1'b0;
        repeat (6) step();
        check("b2b_done_w0", 32'(done_cnt[0]), 32'd3);

        // Second request while busy is ignored by the slower instances
        clear_counts();
        r = 1'b1; addr = 1;
        step();
        r = 1'b0;
        repeat (2) step();
        r = 1'b1; addr = 2;
        step();
        r = 1'b0;
        repeat (8) step();
        for (int g = 0; g < NI; g++)
            check($sformatf("ignore_done[%0d]", g), 32'(done_cnt[g]), (g == 0) ? 32'd2 : 32'd1);
        check("ignore_data_w0", 32'(obs_data[0]), 32'h22);
        check("ignore_data_w4", 32'(obs_data[3]), 32'h21);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(255) == 0) begin
                drop_reset();
                step();
                rst = 1'b1;
            end else begin
                ce = ($urandom_range(3) != 0);
                oe = ($urandom_range(3) != 0);
                r  = ($urandom_range(2) == 0);
                w  = ($urandom_range(2) == 0);
                case ($urandom_range(3))
                    0: addr = ADDR_W'($urandom_range(15));
                    1: addr = ADDR_W'(995 + $urandom_range(34));
                    2: addr = ADDR_W'($urandom);
                    default: addr = ADDR_W'($urandom_range(7));
                endcase
                in_data = DATA_W'($urandom);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
